// File: rtl/mpmc9_ch_arbiter_if.sv
// mpmc9 channel arbiter bus: requests and controller status in,
// grant code, one-hot grant, start strobe and busy out.
interface mpmc9_ch_arbiter_if #(
  parameter int NCH = 8
);
  logic [NCH-1:0] req;
  logic           mem_ready;
  logic           done;
  logic [3:0]     ch;
  logic [NCH-1:0] gnt;
  logic           start;
  logic           busy;

  // controller / port side
  modport master (
    output req, mem_ready, done,
    input  ch, gnt, start, busy
  );

  // arbiter side
  modport slave (
    input  req, mem_ready, done,
    output ch, gnt, start, busy
  );
endinterface

// File: rtl/mpmc9_ch_arbiter.sv
// Round-robin channel arbiter for the eight mpmc9 memory ports.
// Define MPMC9_STARVE_EN to add starvation-priority override.
module mpmc9_ch_arbiter #(
  parameter int         NCH          = 8,
  parameter int         STARVE_LIMIT = 64,
  parameter logic [3:0] IDLE_CH      = 4'hF
) (
  input logic               clk,
  input logic               rst,
  mpmc9_ch_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    A_IDLE,
    A_SETUP,
    A_BUSY
  } state_t;

  state_t         r_state;
  logic [2:0]     r_rr;
  logic [3:0]     r_ch;
  logic [NCH-1:0] r_gnt;
  logic           r_start;
  logic           r_busy;

  logic [2*NCH-1:0] w_req2;
  logic [NCH-1:0]   w_rot;
  logic [2:0]       w_off;
  logic [3:0]       w_sum;
  logic [2:0]       w_rr_win;
  logic [2:0]       w_win;
  logic [2:0]       w_nxt_rr;

  // rotate requests so bit 0 is the channel at the rr pointer
  always_comb begin
    w_req2 = {bus.req, bus.req};
    w_rot  = NCH'(w_req2 >> r_rr);
  end

  // first set bit of the rotated vector, mapped back to a channel
  always_comb begin
    w_off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
    w_sum    = {1'b0, r_rr} + {1'b0, w_off};
    w_rr_win = (w_sum >= 4'(NCH)) ? 3'(w_sum - 4'(NCH))
                                  : w_sum[2:0];
  end

  // pointer after the current owner, wrapping at NCH
  always_comb begin
    w_nxt_rr = (r_ch[2:0] == 3'(NCH - 1)) ? 3'd0
                                          : r_ch[2:0] + 3'd1;
  end

`ifdef MPMC9_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT) + 1;

  logic [CW-1:0]  r_cnt [NCH];
  logic [NCH-1:0] w_starved;
  logic [2:0]     w_st_win;

  // a channel is starved only while it is still requesting
  always_comb begin
    w_starved = '0;
    for (int i = 0; i < NCH; i++) begin
      w_starved[i] = bus.req[i] &&
                     (r_cnt[i] >= CW'(STARVE_LIMIT));
    end
  end

  // lowest starved index takes priority
  always_comb begin
    w_st_win = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_starved[i]) w_st_win = 3'(i);
    end
  end

  assign w_win = (|w_starved) ? w_st_win : w_rr_win;

  // saturating wait counters, cleared on grant or idle request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!bus.req[i] || r_gnt[i])
          r_cnt[i] <= '0;
        else if (r_cnt[i] < CW'(STARVE_LIMIT))
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end
`else
  logic w_unused_cfg;

  assign w_win        = w_rr_win;
  assign w_unused_cfg = |STARVE_LIMIT;
`endif

  // arbitration FSM with registered grant outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= A_IDLE;
      r_rr    <= '0;
      r_ch    <= IDLE_CH;
      r_gnt   <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        A_IDLE: begin
          r_start <= 1'b0;
          if (bus.mem_ready && |bus.req) begin
            r_ch    <= {1'b0, w_win};
            r_gnt   <= NCH'(1) << w_win;
            r_busy  <= 1'b1;
            r_state <= A_SETUP;
          end
        end
        A_SETUP: begin
          r_start <= 1'b1;
          r_state <= A_BUSY;
        end
        A_BUSY: begin
          r_start <= 1'b0;
          // done coincident with the start strobe is not honoured
          if (bus.done && !r_start) begin
            r_ch    <= IDLE_CH;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_rr    <= w_nxt_rr;
            r_state <= A_IDLE;
          end
        end
        default: begin
          r_state <= A_IDLE;
        end
      endcase
    end
  end

  assign bus.ch    = r_ch;
  assign bus.gnt   = r_gnt;
  assign bus.start = r_start;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_mpmc9_ch_arbiter.sv
// Bench for mpmc9_ch_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_mpmc9_ch_arbiter;

`ifdef MPMC9_STARVE_EN
  localparam int SL = 4;
`else
  localparam int SL = 64;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mpmc9_ch_arbiter_if #(.NCH(8)) bus ();

  mpmc9_ch_arbiter #(
    .NCH         (8),
    .STARVE_LIMIT(SL),
    .IDLE_CH     (4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: owner (-1 = none), cycles since grant, pointer
  int rr_m;
  int own;
  int age;
  int wait_m [8];
  int starts [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    rr_m = 0;
    own  = -1;
    age  = 0;
    for (int i = 0; i < 8; i++) wait_m[i] = 0;
  endtask

  function automatic int pick(input logic [7:0] r);
    int w;
    w = -1;
`ifdef MPMC9_STARVE_EN
    for (int i = 7; i >= 0; i--)
      if (r[i] && wait_m[i] >= SL) w = i;
    if (w >= 0) return w;
`endif
    for (int k = 7; k >= 0; k--)
      if (r[(rr_m + k) % 8]) w = (rr_m + k) % 8;
    return w;
  endfunction

  // advance the model by one clock edge using the sampled inputs
  task automatic mdl_edge();
    int old_own;
    logic [7:0] r;
    r = bus.req;
    old_own = own;
    if (own < 0) begin
      if (bus.mem_ready && r != 0) begin
        own = pick(r);
        age = 0;
      end
    end else if (age == 0) begin
      age = 1;
    end else if (bus.done && age >= 2) begin
      rr_m = (own + 1) % 8;
      own  = -1;
    end else begin
      age++;
    end
    for (int i = 0; i < 8; i++) begin
      if (!r[i] || old_own == i) wait_m[i] = 0;
      else if (wait_m[i] < SL) wait_m[i]++;
    end
  endtask

  task automatic cmp_out();
    logic [3:0] e_ch;
    logic [7:0] e_gnt;
    e_ch  = (own < 0) ? 4'hF : 4'(own);
    e_gnt = (own < 0) ? 8'h00 : 8'(1 << own);
    chk("ch", 32'(bus.ch), 32'(e_ch));
    chk("gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("busy", 32'(bus.busy), 32'(own >= 0));
    chk("start", 32'(bus.start), 32'(own >= 0 && age == 1));
  endtask

  task automatic drv(input logic [7:0] r,
                     input logic m,
                     input logic d);
    bus.req       = r;
    bus.mem_ready = m;
    bus.done      = d;
  endtask

  task automatic step();
    @(posedge clk);
    mdl_edge();
    @(negedge clk);
    cmp_out();
    if (bus.start === 1'b1) starts.push_back(int'(bus.ch));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(8'h00, 1'b0, 1'b0);
    #1;
    mdl_reset();
    chk("rst_ch", 32'(bus.ch), 32'hF);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_start", 32'(bus.start), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // wait for a start, hold the transaction, then pulse done
  task automatic serve(input logic [7:0] r, input int hold);
    int w;
    w = 0;
    drv(r, 1'b1, 1'b0);
    while (bus.start !== 1'b1 && w < 12) begin
      step();
      w++;
    end
    if (w >= 12) chk("start_wait", 32'h0, 32'h1);
    repeat (hold) step();
    drv(r, 1'b1, 1'b1);
    step();
    drv(r, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] r;
    drv(8'h00, 1'b0, 1'b0);
    #2;
    do_reset();

    // single request on channel 4
    drv(8'h10, 1'b1, 1'b0);
    step();
    chk("single_ch", 32'(bus.ch), 32'h4);
    chk("single_nostart", 32'(bus.start), 32'h0);
    step();
    chk("single_start", 32'(bus.start), 32'h1);
    chk("single_gnt", 32'(bus.gnt), 32'h10);
    drv(8'h00, 1'b1, 1'b0);
    repeat (3) step();
    drv(8'h00, 1'b1, 1'b1);
    step();
    drv(8'h00, 1'b1, 1'b0);
    chk("single_idle", 32'(bus.ch), 32'hF);
    chk("single_free", 32'(bus.busy), 32'h0);

    // round robin with all channels requesting
    do_reset();
    starts.delete();
    for (int g = 0; g < 9; g++) serve(8'hFF, 4);
    chk("rr_count", 32'(starts.size()), 32'd9);
    for (int g = 0; g < 9 && g < starts.size(); g++)
      chk("rr_order", 32'(starts[g]), 32'(g % 8));

    // pointer wrap and skip: rr=6, req=05 gives 0 then 2
    do_reset();
    starts.delete();
    serve(8'h20, 1);
    serve(8'h05, 1);
    serve(8'h05, 1);
    chk("wrap_count", 32'(starts.size()), 32'd3);
    if (starts.size() == 3) begin
      chk("wrap_first", 32'(starts[1]), 32'd0);
      chk("wrap_second", 32'(starts[2]), 32'd2);
    end

    // stall while memory not ready
    do_reset();
    drv(8'h01, 1'b0, 1'b0);
    repeat (10) step();
    chk("stall_start", 32'(bus.start), 32'h0);
    chk("stall_ch", 32'(bus.ch), 32'hF);
    drv(8'h01, 1'b1, 1'b0);
    step();
    step();
    chk("stall_go", 32'(bus.start), 32'h1);
    step();
    drv(8'h00, 1'b1, 1'b1);
    step();
    drv(8'h00, 1'b1, 1'b0);
    step();

    // asynchronous reset during a transaction on channel 3
    do_reset();
    drv(8'h08, 1'b1, 1'b0);
    repeat (4) step();
    chk("mid_ch_pre", 32'(bus.ch), 32'h3);
    do_reset();
    drv(8'h08, 1'b1, 1'b0);
    step();
    chk("mid_regrant", 32'(bus.ch), 32'h3);
    serve(8'h08, 1);

`ifdef MPMC9_STARVE_EN
    // channel 7 waits long, channel 2 joins late: 7 wins
    do_reset();
    starts.delete();
    drv(8'h02, 1'b1, 1'b0);
    step();
    drv(8'h82, 1'b1, 1'b0);
    repeat (6) step();
    drv(8'h86, 1'b1, 1'b0);
    step();
    drv(8'h86, 1'b1, 1'b1);
    step();
    drv(8'h86, 1'b1, 1'b0);
    step();
    chk("starve_win", 32'(bus.ch), 32'h7);
    serve(8'h86, 2);
`endif

    // random traffic, including stray done and req churn
    do_reset();
    r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(2) == 0) r = 8'($urandom);
      drv(r, $urandom_range(3) != 0, $urandom_range(3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
